// File: rtl/dyn_credit_tx.sv
// ---------------------------------------------------------------------------
// dyn_credit_tx
//
// Credit-based transmit stage for one direction of a tile's dynamic network.
// Flits from the router output are buffered in a small skid FIFO and sent to
// the neighbouring tile only while the local copy of the neighbour's free
// input-buffer slots (credits) is non-zero. Each flit sent costs one credit.
// Each yummy_in pulse from the neighbour returns one credit.
//
// Parameters
//   DATA_W     : flit width in bits
//   CREDITS    : neighbour input-buffer depth (reset and maximum credit count)
//   FIFO_DEPTH : local skid FIFO depth (power of two, >= 2)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   router presents a flit
//   in_data    in   flit from the router
//   in_ready   out  FIFO has room; a flit transfers on in_valid && in_ready
//   out_valid  out  registered one-cycle pulse per flit sent
//   out_data   out  registered flit; holds its last value between sends
//   yummy_in   in   one-cycle pulse: neighbour freed one buffer slot
//   credit_cnt out  current credits
//   fifo_cnt   out  current FIFO occupancy
//   credit_err out  sticky: yummy_in arrived with credits already full and
//                   no send in that cycle
// ---------------------------------------------------------------------------
module dyn_credit_tx #(
   parameter int DATA_W     = 64,
   parameter int CREDITS    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   input  logic [DATA_W-1:0]                 in_data,
   output logic                              in_ready,
   output logic                              out_valid,
   output logic [DATA_W-1:0]                 out_data,
   input  logic                              yummy_in,
   output logic [$clog2(CREDITS+1)-1:0]      credit_cnt,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
   output logic                              credit_err
);

   localparam int CW = $clog2(CREDITS + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
   localparam logic [FW-1:0] FIFO_FULL  = FW'(FIFO_DEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [FW-1:0]     r_fifo_cnt;
   logic [CW-1:0]     r_credit_cnt;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_credit_err;

   // ------------------------------------------------------------------------
   // Handshake and send decision, all from registered state
   // ------------------------------------------------------------------------
   logic w_in_ready;
   logic w_push;
   logic w_send;

   // in_ready looks only at registered occupancy, never at this cycle's pop,
   // so a full FIFO refuses a push even in a cycle where it also sends.
   assign w_in_ready = (r_fifo_cnt < FIFO_FULL);
   assign w_push     = in_valid && w_in_ready;
   assign w_send     = (r_fifo_cnt != '0) && (r_credit_cnt != '0);

   // ------------------------------------------------------------------------
   // FIFO storage
   // ------------------------------------------------------------------------
   // NOTE: the data array has no reset; occupancy and pointers alone decide
   // which entries are live, so resetting the array would only add reset
   // fan-out without changing behaviour.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // ------------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ------------------------------------------------------------------------
   // NOTE: every register here uses non-blocking assignment so all updates in
   // an edge see the pre-edge values of r_fifo_cnt / r_credit_cnt.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         // Pointers wrap naturally because FIFO_DEPTH is a power of two.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_send) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_send})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + FW'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - FW'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Credit counter and sticky overflow flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_credit_cnt <= CREDIT_MAX;
         r_credit_err <= 1'b0;
      end else begin
         unique case ({w_send, yummy_in})
            2'b10: r_credit_cnt <= r_credit_cnt - CW'(1);
            2'b01: begin
               // A return with the counter already full means the neighbour
               // handed back a slot we never used: saturate and flag it.
               if (r_credit_cnt == CREDIT_MAX) begin
                  r_credit_err <= 1'b1;
               end else begin
                  r_credit_cnt <= r_credit_cnt + CW'(1);
               end
            end
            // Send and return in the same cycle cancel out.
            default: r_credit_cnt <= r_credit_cnt;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output register: one pulse per send, data held between sends
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= w_send;
         if (w_send) begin
            r_out_data <= r_mem[r_rd_ptr];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign credit_cnt = r_credit_cnt;
   assign fifo_cnt   = r_fifo_cnt;
   assign credit_err = r_credit_err;

endmodule

// File: tb/tb_dyn_credit_tx.sv
// ---------------------------------------------------------------------------
// tb_dyn_credit_tx
//
// Directed bench for dyn_credit_tx with default parameters (DATA_W=64,
// CREDITS=4, FIFO_DEPTH=4). A table of per-cycle records gives the inputs
// applied before a clock edge and the outputs expected just after it,
// followed by hand-written sequences for the long full-FIFO hold and the
// credit-return ordering.
// ---------------------------------------------------------------------------
module tb_dyn_credit_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic        yummy_in;
   logic [2:0]  credit_cnt;
   logic [2:0]  fifo_cnt;
   logic        credit_err;

   int n_vec = 0;
   int n_err = 0;

   dyn_credit_tx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .yummy_in   (yummy_in),
      .credit_cnt (credit_cnt),
      .fifo_cnt   (fifo_cnt),
      .credit_err (credit_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        in_valid;
      logic [63:0] in_data;
      logic        yummy;
      logic        e_ov;
      logic [63:0] e_od;
      logic [2:0]  e_cr;
      logic [2:0]  e_fc;
      logic        e_rdy;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [63:0] d,
                      input logic y, input logic eov, input logic [63:0] eod,
                      input logic [2:0] ecr, input logic [2:0] efc,
                      input logic erdy, input logic eerr);
      vec_t t;
      t.rst_n = r;   t.in_valid = v; t.in_data = d;   t.yummy = y;
      t.e_ov  = eov; t.e_od = eod;   t.e_cr = ecr;    t.e_fc = efc;
      t.e_rdy = erdy; t.e_err = eerr;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs, then sample just after the next rising edge.
   task automatic step(input logic r, input logic v, input logic [63:0] d,
                       input logic y);
      rst_n = r; in_valid = v; in_data = d; yummy_in = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] sent[$];
      int          ov_seen;
      int          lat;
      bit          got;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; yummy_in = 1'b0;

      //   rst v  data   y | ov od     cr fc rdy err
      // reset held two cycles, then released
      add(0, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      add(0, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      // single flit: accepted, sent one edge later, one-cycle pulse
      add(1, 1, 64'hA5, 0,  0, 64'h0,  4, 1, 1, 0);
      add(1, 0, 64'h0,  0,  1, 64'hA5, 3, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'hA5, 3, 0, 1, 0);
      add(1, 0, 64'h0,  1,  0, 64'hA5, 4, 0, 1, 0);
      // credit exhaustion: 1..6 back to back, 5 and 6 stay queued
      add(1, 1, 64'h1,  0,  0, 64'hA5, 4, 1, 1, 0);
      add(1, 1, 64'h2,  0,  1, 64'h1,  3, 1, 1, 0);
      add(1, 1, 64'h3,  0,  1, 64'h2,  2, 1, 1, 0);
      add(1, 1, 64'h4,  0,  1, 64'h3,  1, 1, 1, 0);
      add(1, 1, 64'h5,  0,  1, 64'h4,  0, 1, 1, 0);
      add(1, 1, 64'h6,  0,  0, 64'h4,  0, 2, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h4,  0, 2, 1, 0);
      // two yummies release 5 then 6; credits back to 0
      add(1, 0, 64'h0,  1,  0, 64'h4,  1, 2, 1, 0);
      add(1, 0, 64'h0,  1,  1, 64'h5,  1, 1, 1, 0);
      add(1, 0, 64'h0,  0,  1, 64'h6,  0, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h6,  0, 0, 1, 0);
      // build credit to 2, then send with yummy every cycle
      add(1, 0, 64'h0,  1,  0, 64'h6,  1, 0, 1, 0);
      add(1, 0, 64'h0,  1,  0, 64'h6,  2, 0, 1, 0);
      add(1, 1, 64'h10, 0,  0, 64'h6,  2, 1, 1, 0);
      add(1, 1, 64'h11, 1,  1, 64'h10, 2, 1, 1, 0);
      add(1, 1, 64'h12, 1,  1, 64'h11, 2, 1, 1, 0);
      add(1, 1, 64'h13, 1,  1, 64'h12, 2, 1, 1, 0);
      add(1, 0, 64'h0,  1,  1, 64'h13, 2, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h13, 2, 0, 1, 0);
      // spend the last two credits
      add(1, 1, 64'h20, 0,  0, 64'h13, 2, 1, 1, 0);
      add(1, 1, 64'h21, 0,  1, 64'h20, 1, 1, 1, 0);
      add(1, 0, 64'h0,  0,  1, 64'h21, 0, 0, 1, 0);
      // zero credits: fill the FIFO, extra pushes refused
      add(1, 1, 64'h30, 0,  0, 64'h21, 0, 1, 1, 0);
      add(1, 1, 64'h31, 0,  0, 64'h21, 0, 2, 1, 0);
      add(1, 1, 64'h32, 0,  0, 64'h21, 0, 3, 1, 0);
      add(1, 1, 64'h33, 0,  0, 64'h21, 0, 4, 0, 0);
      add(1, 1, 64'h34, 0,  0, 64'h21, 0, 4, 0, 0);
      // full: one credit back, pop while full does not admit the push
      add(1, 1, 64'h35, 1,  0, 64'h21, 1, 4, 0, 0);
      add(1, 1, 64'h35, 0,  1, 64'h30, 0, 3, 1, 0);
      add(1, 0, 64'h0,  1,  0, 64'h30, 1, 3, 1, 0);
      // reset mid-stream with fifo=3, credit=1; nothing stale afterwards
      add(0, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      // yummy with full credits and empty FIFO: sticky error, count held
      add(1, 0, 64'h0,  1,  0, 64'h0,  4, 0, 1, 1);
      add(1, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 1);
      // reset clears the flag; yummy at full credits alongside a send is fine
      add(0, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h0,  4, 0, 1, 0);
      add(1, 1, 64'h40, 0,  0, 64'h0,  4, 1, 1, 0);
      add(1, 0, 64'h0,  1,  1, 64'h40, 4, 0, 1, 0);
      add(1, 0, 64'h0,  0,  0, 64'h40, 4, 0, 1, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].in_valid, vecs[i].in_data, vecs[i].yummy);
         check($sformatf("v%0d out_valid", i),  64'(out_valid),  64'(vecs[i].e_ov));
         check($sformatf("v%0d out_data", i),   out_data,        vecs[i].e_od);
         check($sformatf("v%0d credit_cnt", i), 64'(credit_cnt), 64'(vecs[i].e_cr));
         check($sformatf("v%0d fifo_cnt", i),   64'(fifo_cnt),   64'(vecs[i].e_fc));
         check($sformatf("v%0d in_ready", i),   64'(in_ready),   64'(vecs[i].e_rdy));
         check($sformatf("v%0d credit_err", i), 64'(credit_err), 64'(vecs[i].e_err));
      end

      // ---- Full FIFO with zero credits holds indefinitely ----
      for (int k = 0; k < 4; k++) step(1, 1, 64'h50 + 64'(k), 0);
      step(1, 0, 64'h0, 0);
      step(1, 0, 64'h0, 0);
      check("drain credit_cnt", 64'(credit_cnt), 64'd0);
      check("drain fifo_cnt",   64'(fifo_cnt),   64'd0);
      for (int k = 0; k < 4; k++) step(1, 1, 64'h60 + 64'(k), 0);
      ov_seen = 0;
      for (int k = 0; k < 20; k++) begin
         step(1, 1, 64'hEE, 0);
         if (out_valid) ov_seen++;
      end
      check("hold out_valid pulses", 64'(ov_seen),   64'd0);
      check("hold fifo_cnt",         64'(fifo_cnt),  64'd4);
      check("hold in_ready",         64'(in_ready),  64'd0);

      // ---- One yummy: send exactly one edge later, head flit first ----
      step(1, 0, 64'h0, 1);
      check("stall out_valid", 64'(out_valid), 64'd0);
      got = 1'b0;
      lat = 0;
      for (int k = 0; k < 4 && !got; k++) begin
         step(1, 0, 64'h0, 0);
         lat++;
         if (out_valid) got = 1'b1;
      end
      check("yummy send seen",    64'(got), 64'd1);
      check("yummy send latency", 64'(lat), 64'd1);
      check("yummy send data",    out_data, 64'h60);

      // ---- Three more yummies release the rest in order ----
      for (int k = 0; k < 6; k++) begin
         step(1, 0, 64'h0, (k < 3) ? 1'b1 : 1'b0);
         if (out_valid) sent.push_back(out_data);
      end
      check("order count", 64'(sent.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < sent.size())
            check($sformatf("order flit %0d", k), sent[k], 64'h61 + 64'(k));
      end
      check("final credit_cnt", 64'(credit_cnt), 64'd0);
      check("final fifo_cnt",   64'(fifo_cnt),   64'd0);
      check("final credit_err", 64'(credit_err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
